mips_cpu_regwrite_arbiter: RTL and testbench

Write-back arbiter that shares the register file's single write port between the ALU result path and the memory-load result path. Same-cycle conflicts are resolved in program order. Losing or blocked writes are held in a small in-order queue. A per-register pending mask lets decode stall on registers with writes still in flight. It sits between the execute/memory stages and `mips_cpu_registers`, driving that block's `writeEnable`/`writeAddress`/`dataIn`.

---
 rtl/mips_cpu_wb_pkg.sv | 20 ++
 rtl/mips_cpu_wb_fifo.sv | 72 +++++++
 rtl/mips_cpu_regwrite_arbiter.sv | 126 ++++++++++++
 tb/tb_mips_cpu_regwrite_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_wb_pkg.sv
// Shared types and helpers for the register-file write-back path.
package mips_cpu_wb_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    // One pending register write: destination and value.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // One-hot decode of a register number, used to build the pending mask.
    function automatic logic [31:0] onehot32(input logic [ADDR_W-1:0] addr);
        return 32'(1) << addr;
    endfunction

endpackage

// File: rtl/mips_cpu_wb_fifo.sv
// In-order queue of deferred register writes: two ordered pushes and one pop per cycle.
module mips_cpu_wb_fifo
    import mips_cpu_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push0_valid,
    input  wb_req_t                        push0_req,
    input  logic                           push1_valid,
    input  wb_req_t                        push1_req,
    input  logic                           pop,
    output wb_req_t                        head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [DEPTH-1:0]               entry_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]   entry_addr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_req_t           store_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     wr_ptr_1;
    logic [CW-1:0]     count_q;
    logic [DEPTH-1:0]  valid_q;

    // Pointer increment with wrap at DEPTH (DEPTH need not be a power of two).
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign wr_ptr_1 = ptr_inc(wr_ptr_q);

    // Pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
        end else begin
            if (pop) begin
                rd_ptr_q          <= ptr_inc(rd_ptr_q);
                valid_q[rd_ptr_q] <= 1'b0;
            end
            if (push0_valid) valid_q[wr_ptr_q] <= 1'b1;
            if (push1_valid) valid_q[wr_ptr_1] <= 1'b1;
            if (push1_valid)      wr_ptr_q <= ptr_inc(wr_ptr_1);
            else if (push0_valid) wr_ptr_q <= wr_ptr_1;
            count_q <= count_q + CW'(push0_valid) + CW'(push1_valid) - CW'(pop);
        end
    end

    // Entry payload storage; contents are meaningless unless the valid bit is set.
    always_ff @(posedge clk) begin
        if (push0_valid) store_q[wr_ptr_q] <= push0_req;
        if (push1_valid) store_q[wr_ptr_1] <= push1_req;
    end

    assign head        = store_q[rd_ptr_q];
    assign count       = count_q;
    assign entry_valid = valid_q;

    // Expose each entry's destination for the pending-mask OR tree.
    for (genvar i = 0; i < DEPTH; i++) begin : g_addr
        assign entry_addr[i] = store_q[i].addr;
    end

endmodule

// File: rtl/mips_cpu_regwrite_arbiter.sv
// Shares the register file write port between the ALU and load paths in program order.
module mips_cpu_regwrite_arbiter
    import mips_cpu_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        alu_valid,
    input  logic [4:0]                  alu_addr,
    input  logic [31:0]                 alu_data,
    output logic                        alu_ready,
    input  logic                        mem_valid,
    input  logic [4:0]                  mem_addr,
    input  logic [31:0]                 mem_data,
    output logic                        mem_ready,
    output logic                        rf_write_enable,
    output logic [4:0]                  rf_write_address,
    output logic [31:0]                 rf_data_in,
    output logic [31:0]                 pending_mask,
    output logic [$clog2(DEPTH+1)-1:0]  queue_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                            ready;
    logic                            mem_acc;
    logic                            alu_acc;
    logic                            q_empty;
    logic                            mem_push;
    logic                            alu_push;
    logic                            issue_valid;
    wb_req_t                         issue_req;
    wb_req_t                         mem_req;
    wb_req_t                         alu_req;
    wb_req_t                         head;
    logic                            push0_valid;
    logic                            push1_valid;
    wb_req_t                         push0_req;
    logic                            pop;
    logic [CW-1:0]                   count;
    logic [DEPTH-1:0]                entry_valid;
    logic [DEPTH-1:0][ADDR_W-1:0]    entry_addr;

    // Readiness depends only on occupancy so two pushes can never overflow.
    assign ready     = (count <= CW'(DEPTH - 2));
    assign alu_ready = ready;
    assign mem_ready = ready;

    assign mem_req = '{addr: mem_addr, data: mem_data};
    assign alu_req = '{addr: alu_addr, data: alu_data};

    // Writes to r0 are consumed here and never travel further.
    assign mem_acc = mem_valid && ready && (mem_addr != REG_ZERO);
    assign alu_acc = alu_valid && ready && (alu_addr != REG_ZERO);
    assign q_empty = (count == '0);

    // Oldest first: queue head, then same-cycle load, then same-cycle ALU result.
    always_comb begin
        issue_valid = 1'b0;
        issue_req   = '0;
        pop         = 1'b0;
        if (!q_empty) begin
            issue_valid = 1'b1;
            issue_req   = head;
            pop         = 1'b1;
        end else if (mem_acc) begin
            issue_valid = 1'b1;
            issue_req   = mem_req;
        end else if (alu_acc) begin
            issue_valid = 1'b1;
            issue_req   = alu_req;
        end
    end

    // Everything accepted but not issued is queued, load before ALU.
    always_comb begin
        mem_push    = mem_acc && !q_empty;
        alu_push    = alu_acc && (!q_empty || mem_acc);
        push0_valid = mem_push || alu_push;
        push0_req   = mem_push ? mem_req : alu_req;
        push1_valid = mem_push && alu_push;
    end

    mips_cpu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push0_valid (push0_valid),
        .push0_req   (push0_req),
        .push1_valid (push1_valid),
        .push1_req   (alu_req),
        .pop         (pop),
        .head        (head),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_addr  (entry_addr)
    );

    assign queue_count = count;

    // Register the issued write onto the register file port.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_write_enable  <= 1'b0;
            rf_write_address <= '0;
            rf_data_in       <= '0;
        end else begin
            rf_write_enable <= issue_valid;
            if (issue_valid) begin
                rf_write_address <= issue_req.addr;
                rf_data_in       <= issue_req.data;
            end
        end
    end

    // Registers with a write still queued or sitting on the rf port.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) pending_mask = pending_mask | onehot32(entry_addr[i]);
        end
        if (rf_write_enable) pending_mask = pending_mask | onehot32(rf_write_address);
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_mips_cpu_regwrite_arbiter.sv
// Directed bench for the write-back arbiter with a program-order expectation queue.
module tb_mips_cpu_regwrite_arbiter;
    import mips_cpu_wb_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        alu_valid;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [4:0]  mem_addr;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_write_address;
    logic [31:0] rf_data_in;
    logic [31:0] pending_mask;
    logic [$clog2(DEPTH+1)-1:0] queue_count;

    int tests = 0;
    int fails = 0;

    // Accepted nonzero writes not yet issued, oldest first.
    wb_req_t sb[$];

    mips_cpu_regwrite_arbiter #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .alu_valid        (alu_valid),
        .alu_addr         (alu_addr),
        .alu_data         (alu_data),
        .alu_ready        (alu_ready),
        .mem_valid        (mem_valid),
        .mem_addr         (mem_addr),
        .mem_data         (mem_data),
        .mem_ready        (mem_ready),
        .rf_write_enable  (rf_write_enable),
        .rf_write_address (rf_write_address),
        .rf_data_in       (rf_data_in),
        .pending_mask     (pending_mask),
        .queue_count      (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given requests; checks ready now and the rf port/queue/mask after the edge.
    task automatic do_cycle(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                            input logic av, input logic [4:0] aa, input logic [31:0] ad,
                            output logic acc);
        logic    rdy;
        logic    iss_v;
        wb_req_t iss;
        wb_req_t tmp;
        logic [31:0] m;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        alu_valid = av; alu_addr = aa; alu_data = ad;
        rdy = (sb.size() <= int'(DEPTH) - 2);
        chk("alu_ready", 32'(alu_ready), 32'(rdy));
        chk("mem_ready", 32'(mem_ready), 32'(rdy));
        acc = rdy;
        if (rdy && mv && ma != 5'd0) begin tmp.addr = ma; tmp.data = md; sb.push_back(tmp); end
        if (rdy && av && aa != 5'd0) begin tmp.addr = aa; tmp.data = ad; sb.push_back(tmp); end
        iss_v = (sb.size() != 0);
        iss   = '0;
        if (iss_v) iss = sb.pop_front();
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        alu_valid = 1'b0;
        chk("rf_we", 32'(rf_write_enable), 32'(iss_v));
        if (iss_v) begin
            chk("rf_addr", 32'(rf_write_address), 32'(iss.addr));
            chk("rf_data", rf_data_in, iss.data);
        end
        chk("queue_count", 32'(queue_count), 32'(sb.size()));
        m = '0;
        for (int k = 0; k < sb.size(); k++) m = m | (32'(1) << sb[k].addr);
        if (iss_v) m = m | (32'(1) << iss.addr);
        chk("pending_mask", pending_mask, m);
    endtask

    task automatic idle_cycle();
        logic a;
        do_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a);
    endtask

    task automatic drain();
        while (sb.size() != 0) idle_cycle();
        idle_cycle();
    endtask

    initial begin
        logic acc;
        int   n;
        int   i;

        // Reset held with a live ALU request.
        reset_n   = 1'b0;
        mem_valid = 1'b0; mem_addr = 5'd0; mem_data = 32'd0;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(rf_write_enable), 32'd0);
        chk("rst_addr", 32'(rf_write_address), 32'd0);
        chk("rst_data", rf_data_in, 32'd0);
        chk("rst_mask", pending_mask, 32'd0);
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        reset_n = 1'b1;
        do_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11, acc);
        chk("first_addr", 32'(rf_write_address), 32'd5);
        chk("first_data", rf_data_in, 32'h11);
        drain();

        // Same-cycle pair to one register: load first, then ALU.
        do_cycle(1'b1, 5'd3, 32'hA, 1'b1, 5'd3, 32'hB, acc);
        chk("pair_t1_data", rf_data_in, 32'hA);
        chk("pair_t1_mask3", 32'(pending_mask[3]), 32'd1);
        idle_cycle();
        chk("pair_t2_data", rf_data_in, 32'hB);
        chk("pair_t2_mask3", 32'(pending_mask[3]), 32'd1);
        idle_cycle();
        chk("pair_t3_mask3", 32'(pending_mask[3]), 32'd0);

        // Zero register on the ALU side alongside a load.
        do_cycle(1'b1, 5'd7, 32'h7, 1'b1, 5'd0, 32'hFFFF, acc);
        chk("zero_addr", 32'(rf_write_address), 32'd7);
        chk("zero_count", 32'(queue_count), 32'd0);
        chk("zero_mask0", 32'(pending_mask[0]), 32'd0);
        idle_cycle();
        chk("zero_mask0_b", 32'(pending_mask[0]), 32'd0);

        // Saturation: both requesters every cycle, addresses 1..31 in order.
        n = 1;
        while (n <= 31) begin
            do_cycle(1'b1, 5'(n), 32'h1000 + 32'(n), (n < 31), 5'(n + 1), 32'h1000 + 32'(n + 1), acc);
            if (acc) n += 2;
        end
        drain();

        // Fill the queue to three entries, then pulse reset between edges.
        do_cycle(1'b1, 5'd10, 32'h100, 1'b1, 5'd11, 32'h101, acc);
        do_cycle(1'b1, 5'd12, 32'h102, 1'b1, 5'd13, 32'h103, acc);
        do_cycle(1'b1, 5'd14, 32'h104, 1'b1, 5'd15, 32'h105, acc);
        chk("pre_rst_count", 32'(queue_count), 32'd3);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(rf_write_enable), 32'd0);
        chk("mid_rst_addr", 32'(rf_write_address), 32'd0);
        chk("mid_rst_data", rf_data_in, 32'd0);
        chk("mid_rst_count", 32'(queue_count), 32'd0);
        chk("mid_rst_mask", pending_mask, 32'd0);
        chk("mid_rst_ready", 32'(alu_ready & mem_ready), 32'd1);
        #1;
        reset_n = 1'b1;
        sb.delete();
        repeat (4) idle_cycle();

        // Wrap-around: alternating paired and single requests with repeated registers.
        i = 0;
        while (i < 3 * int'(DEPTH)) begin
            if (i % 2 == 0)
                do_cycle(1'b1, 5'((i % 6) + 1), 32'hA000 + 32'(i * 16 + 1),
                         1'b1, 5'((i % 4) + 8), 32'hA000 + 32'(i * 16 + 2), acc);
            else if (i % 4 == 1)
                do_cycle(1'b1, 5'((i % 6) + 1), 32'hB000 + 32'(i), 1'b0, 5'd0, 32'd0, acc);
            else
                do_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'((i % 4) + 8), 32'hC000 + 32'(i), acc);
            if (acc) i++;
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
